button_bank: RTL and testbench
==============================

BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  N_CH  4  number of independent button channels
  SYNC_STAGES  2  synchronizer flops per channel, minimum 2
  DEBOUNCE_CYCLES  4  consecutive stable synchronized samples required to accept a change, minimum 1
  HOLD_CYCLES  10  PRESSED cycles before a long-press, minimum 1
  REPEAT_CYCLES  3  auto-repeat period while HELD; 0 disables repeat
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock
  reset  input  1  asynchronous, active-low reset
  enable  input  1  synchronous global enable
  pb_in  input  N_CH  raw asynchronous button levels
  level  output  N_CH  debounced button state
  press  output  N_CH  one-cycle pulse on accepted press
  release  output  N_CH  one-cycle pulse on accepted release
  hold  output  N_CH  one-cycle pulse on long-press
  repeat  output  N_CH  one-cycle auto-repeat pulses

Function
REQ-003 Each channel SHALL pass pb_in[i] through SYNC_STAGES flops; only the last stage (sync[i]) SHALL feed logic.
REQ-004 Each channel SHALL run an independent FSM: IDLE, ARM_PRESS, PRESSED, HELD, ARM_RELEASE.
REQ-005 IDLE: sync=1 -> ARM_PRESS with count=1; if DEBOUNCE_CYCLES=1 -> PRESSED directly.
REQ-006 ARM_PRESS: sync=0 -> IDLE, no pulse; sync=1 -> count++; count reaching DEBOUNCE_CYCLES -> PRESSED.
REQ-007 Entry into PRESSED from ARM_PRESS SHALL assert press[i] and set level[i]=1 on the same edge; hold counter cleared.
REQ-008 With pb_in[i] stable high, press[i] SHALL assert after edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples pb_in[i]=1 as edge 1.
REQ-009 PRESSED: hold counter increments each cycle; reaching HOLD_CYCLES -> HELD with one hold[i] pulse; repeat counter cleared.
REQ-010 HELD: when REPEAT_CYCLES>0, repeat[i] SHALL pulse every REPEAT_CYCLES cycles; first pulse REPEAT_CYCLES cycles after hold[i].
REQ-011 PRESSED/HELD with sync=0 -> ARM_RELEASE; a was_held flag records the origin state.
REQ-012 ARM_RELEASE: hold and repeat counters freeze; sync=1 -> return to the origin state with no pulse.
REQ-013 ARM_RELEASE: DEBOUNCE_CYCLES consecutive sync=0 -> IDLE, one release[i] pulse, level[i]=0 on the same edge.
REQ-014 press, release, hold and repeat SHALL be registered, one cycle wide, and mutually exclusive per channel per cycle.
REQ-015 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce same-cycle pulses.
REQ-016 Counter widths SHALL be $clog2(max+1) of their limit; counters SHALL saturate and never wrap.
REQ-017 enable=0 SHALL force every FSM to IDLE, clear counters, level and all pulses on the next edge, with no release pulse; the synchronizer keeps running.
REQ-018 After enable returns to 1 with a button held, a fresh press SHALL follow after DEBOUNCE_CYCLES.

Reset
REQ-019 reset=0 SHALL asynchronously clear synchronizer flops, FSMs (IDLE), counters, was_held and all outputs to 0.
REQ-020 Reset asserted mid-operation SHALL emit no release pulse; after deassertion with a button held, press SHALL follow per REQ-008.

Structure
REQ-021 Package button_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-022 Per-channel logic SHALL be a sub-module button_channel, instantiated N_CH times by generate in button_bank.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-023 pb_in[0] high for 8 cycles, then low -> press[0] pulses after edge 6; level[0]=1; release[0] pulses 4 cycles after sync goes low; no hold.
REQ-024 pb_in[1] high for 3 cycles, then low -> no pulses; level[1] stays 0.
REQ-025 pb_in[2] held for 30 cycles -> press after edge 6, hold after edge 16, repeat after edges 19/22/25/28 and up to release.
REQ-026 Single-cycle low glitch on pb_in[2] while HELD -> no release; next repeat delayed by exactly the ARM_RELEASE cycles.
REQ-027 All four pb_in rise together -> press[3:0]=4'b1111 in one cycle.
REQ-028 reset=0 mid-HELD -> outputs 0 immediately; release reset with button still high -> press after edge 6, no release pulse.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for the debounced push-button bank.
package button_pkg;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 10;
  localparam int DEF_REPEAT_CYCLES   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM_PRESS,
    ST_PRESSED,
    ST_HELD,
    ST_ARM_RELEASE
  } btn_state_e;

  // Registered per-channel outputs.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold;
    logic rpt;
  } btn_out_t;

  // Width of a counter that must reach max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, debounce FSM, long-press and auto-repeat timers.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  input  logic     pb,
  output btn_out_t out
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  btn_state_e             state;
  logic [DW-1:0]          deb_cnt, deb_nxt;
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic [RW-1:0]          rpt_cnt, rpt_nxt;
  logic                   was_held;

  // Synchronizer is not gated by enable so it is already settled when enable returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Saturating increments.
  always_comb begin
    deb_nxt  = (deb_cnt  == DMAX) ? deb_cnt  : deb_cnt  + DW'(1);
    hold_nxt = (hold_cnt == HMAX) ? hold_cnt : hold_cnt + HW'(1);
    rpt_nxt  = (rpt_cnt  == RMAX) ? rpt_cnt  : rpt_cnt  + RW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      was_held <= 1'b0;
      out      <= '0;
    end else begin
      out.press <= 1'b0;
      out.rel   <= 1'b0;
      out.hold  <= 1'b0;
      out.rpt   <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        rpt_cnt   <= '0;
        was_held  <= 1'b0;
        out.level <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sync) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state     <= ST_PRESSED;
                out.press <= 1'b1;
                out.level <= 1'b1;
                hold_cnt  <= '0;
              end else begin
                state   <= ST_ARM_PRESS;
                deb_cnt <= DW'(1);
              end
            end
          end
          ST_ARM_PRESS: begin
            if (!sync) begin
              state   <= ST_IDLE;
              deb_cnt <= '0;
            end else if (deb_nxt == DMAX) begin
              state     <= ST_PRESSED;
              out.press <= 1'b1;
              out.level <= 1'b1;
              deb_cnt   <= '0;
              hold_cnt  <= '0;
            end else begin
              deb_cnt <= deb_nxt;
            end
          end
          // The cycle that first sees sync low still counts as a PRESSED/HELD
          // cycle, so a glitch only costs the cycles spent in ARM_RELEASE.
          ST_PRESSED, ST_HELD: begin
            if (!sync) begin
              was_held <= (state == ST_HELD);
              if (state == ST_HELD) rpt_cnt  <= rpt_nxt;
              else                  hold_cnt <= hold_nxt;
              if (DEBOUNCE_CYCLES == 1) begin
                state     <= ST_IDLE;
                out.rel   <= 1'b1;
                out.level <= 1'b0;
                hold_cnt  <= '0;
                rpt_cnt   <= '0;
                was_held  <= 1'b0;
              end else begin
                state   <= ST_ARM_RELEASE;
                deb_cnt <= DW'(1);
              end
            end else if (state == ST_PRESSED) begin
              hold_cnt <= hold_nxt;
              if (hold_nxt == HMAX) begin
                state    <= ST_HELD;
                out.hold <= 1'b1;
                rpt_cnt  <= '0;
              end
            end else if (REPEAT_CYCLES > 0) begin
              if (rpt_nxt == RMAX) begin
                out.rpt <= 1'b1;
                rpt_cnt <= '0;
              end else begin
                rpt_cnt <= rpt_nxt;
              end
            end
          end
          ST_ARM_RELEASE: begin
            if (sync) begin
              state   <= was_held ? ST_HELD : ST_PRESSED;
              deb_cnt <= '0;
            end else if (deb_nxt == DMAX) begin
              state     <= ST_IDLE;
              out.rel   <= 1'b1;
              out.level <= 1'b0;
              deb_cnt   <= '0;
              hold_cnt  <= '0;
              rpt_cnt   <= '0;
              was_held  <= 1'b0;
            end else begin
              deb_cnt <= deb_nxt;
            end
          end
          default: begin
            state     <= ST_IDLE;
            out.level <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_bank.sv
// Bank of N_CH independent debounced buttons with press/release/hold/repeat pulses.
module button_bank
  import button_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] repeat_p
);

  btn_out_t ch_out [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .pb    (pb_in[i]),
      .out   (ch_out[i])
    );

    assign level[i]     = ch_out[i].level;
    assign press[i]     = ch_out[i].press;
    assign release_p[i] = ch_out[i].rel;
    assign hold[i]      = ch_out[i].hold;
    assign repeat_p[i]  = ch_out[i].rpt;
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank at the default parameter set.
module tb_button_bank;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] pb_in;
  logic [3:0] level, press, release_p, hold, repeat_p;
  logic [3:0] acc_level, acc_press, acc_rel, acc_hold, acc_rpt;
  int         n_cmp;
  int         n_err;

  button_bank #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pb_in    (pb_in),
    .level    (level),
    .press    (press),
    .release_p(release_p),
    .hold     (hold),
    .repeat_p (repeat_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    acc_level = '0; acc_press = '0; acc_rel = '0; acc_hold = '0; acc_rpt = '0;
  endtask

  // Advance n rising edges, sampling 1 time unit after each and OR-ing outputs.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      acc_level |= level;
      acc_press |= press;
      acc_rel   |= release_p;
      acc_hold  |= hold;
      acc_rpt   |= repeat_p;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; enable = 1'b1; pb_in = 4'b0000;
    clr();
    #1 reset = 1'b0;
    #1 chk("reset.outputs", {level, press, release_p, hold, repeat_p}, 0);
    step(3);
    chk("reset.held", {level, press, release_p, hold, repeat_p}, 0);
    reset = 1'b1;
    step(2);

    // Channel 0: 8 cycles high, then release.
    clr(); pb_in = 4'b0001;
    step(5); chk("A.no_early_press", acc_press, 4'b0000);
    step(1); chk("A.press", press, 4'b0001);
    chk("A.level", level, 4'b0001);
    step(1); chk("A.press_one_cycle", press, 4'b0000);
    clr(); step(1); pb_in = 4'b0000;
    step(5);
    chk("A.no_pulses_before_release", {acc_press, acc_rel, acc_hold, acc_rpt}, 0);
    chk("A.level_in_arm_release", level, 4'b0001);
    step(1); chk("A.release", release_p, 4'b0001);
    chk("A.level_cleared", level, 4'b0000);
    step(1); chk("A.release_one_cycle", release_p, 4'b0000);

    // Channel 1: 3-cycle bounce, rejected.
    clr(); pb_in = 4'b0010;
    step(3); pb_in = 4'b0000;
    step(9);
    chk("B.no_pulses", {acc_press, acc_rel, acc_hold, acc_rpt}, 0);
    chk("B.no_level", acc_level, 4'b0000);

    // Channel 2: long hold, repeats, one-cycle glitch, release.
    clr(); pb_in = 4'b0100;
    step(5); chk("C.no_early_press", acc_press, 4'b0000);
    step(1); chk("C.press", press, 4'b0100);
    clr(); step(9); chk("C.no_early_hold", {acc_hold, acc_rpt}, 0);
    step(1); chk("C.hold", hold, 4'b0100);
    chk("C.hold_excl", {press, release_p, repeat_p}, 0);
    clr(); step(2); chk("C.gap19", acc_rpt, 4'b0000);
    step(1); chk("C.repeat19", repeat_p, 4'b0100);
    clr(); step(2); chk("C.gap22", acc_rpt, 4'b0000);
    step(1); chk("C.repeat22", repeat_p, 4'b0100);
    clr(); step(2); chk("C.gap25", acc_rpt, 4'b0000);
    step(1); chk("C.repeat25", repeat_p, 4'b0100);
    clr(); step(2); chk("C.gap28", acc_rpt, 4'b0000);
    step(1); chk("C.repeat28", repeat_p, 4'b0100);
    step(1); pb_in = 4'b0000;
    step(1); pb_in = 4'b0100;
    step(1); chk("C.repeat31", repeat_p, 4'b0100);
    clr(); step(3);
    chk("C.glitch_quiet", {acc_rpt, acc_rel, acc_press, acc_hold}, 0);
    chk("C.glitch_level", level, 4'b0100);
    step(1); chk("C.repeat_delayed", repeat_p, 4'b0100);
    pb_in = 4'b0000;
    clr(); step(5); chk("C.no_repeat_in_release", {acc_rpt, acc_rel}, 0);
    step(1); chk("C.release", release_p, 4'b0100);
    chk("C.level_cleared", level, 4'b0000);
    clr(); step(6); chk("C.quiet_after", {acc_rpt, acc_hold, acc_press, acc_rel}, 0);

    // All channels together, then async reset mid-HELD.
    clr(); pb_in = 4'b1111;
    step(5); chk("D.no_early_press", acc_press, 4'b0000);
    step(1); chk("D.press_all", press, 4'b1111);
    chk("D.level_all", level, 4'b1111);
    clr(); step(9); chk("D.no_early_hold", acc_hold, 4'b0000);
    step(1); chk("D.hold_all", hold, 4'b1111);
    step(2);
    #1 reset = 1'b0;
    #1 chk("D.async_reset", {level, press, release_p, hold, repeat_p}, 0);
    clr(); step(2);
    chk("D.reset_quiet", {acc_level, acc_press, acc_rel, acc_hold, acc_rpt}, 0);
    reset = 1'b1;
    clr(); step(5);
    chk("D.no_release_after_reset", {acc_press, acc_rel, acc_level}, 0);
    step(1); chk("D.repress", press, 4'b1111);

    // Synchronous enable drop and recovery with buttons held.
    step(1); enable = 1'b0;
    step(1); chk("E.level_cleared", level, 4'b0000);
    chk("E.no_release", release_p, 4'b0000);
    clr(); step(3);
    chk("E.disabled_quiet", {acc_level, acc_press, acc_rel, acc_hold, acc_rpt}, 0);
    enable = 1'b1;
    clr(); step(3); chk("E.no_early_press", acc_press, 4'b0000);
    step(1); chk("E.press_after_enable", press, 4'b1111);
    chk("E.level_after_enable", level, 4'b1111);

    pb_in = 4'b0000;
    step(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
